input_conditioner: RTL and testbench



---
 rtl/input_conditioner_pkg.sv | 14 +
 rtl/input_conditioner_if.sv | 19 +
 rtl/input_conditioner_debounce_filter.sv | 38 +++
 rtl/input_conditioner.sv | 151 +++++++++++++++
 tb/tb_input_conditioner.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared types, default parameters and width helper for the switch input conditioner.
package input_cond_pkg;

  typedef enum logic [1:0] {ARM, IDLE, HELD, LONGHELD} btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 164;
  localparam int DEF_REED_CYCLES     = 16;
  localparam int DEF_LONG_CYCLES     = 65536;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw active-low switch lines in, clean event strobes out.
// ComboLong exists only when INPUT_COMBO_EN is defined.
interface input_cond_if;
  logic nMode, nTrip, nFork, nCrank;
  logic ModeShort, ModeLong, TripShort, TripLong, ForkPulse, CrankPulse;
`ifdef INPUT_COMBO_EN
  logic ComboLong;

  modport master (output nMode, nTrip, nFork, nCrank,
                  input  ModeShort, ModeLong, TripShort, TripLong, ForkPulse, CrankPulse, ComboLong);
  modport slave  (input  nMode, nTrip, nFork, nCrank,
                  output ModeShort, ModeLong, TripShort, TripLong, ForkPulse, CrankPulse, ComboLong);
`else
  modport master (output nMode, nTrip, nFork, nCrank,
                  input  ModeShort, ModeLong, TripShort, TripLong, ForkPulse, CrankPulse);
  modport slave  (input  nMode, nTrip, nFork, nCrank,
                  output ModeShort, ModeLong, TripShort, TripLong, ForkPulse, CrankPulse);
`endif
endinterface

// File: rtl/input_conditioner_debounce_filter.sv
// Stable-count debounce: level flips after the raw input has differed for N samples.
// fall/rise are combinational "flipping on this edge" strobes for the parent to register.
module debounce_filter
  import input_cond_pkg::*;
#(
  parameter int N = 2
)(
  input  logic HCLK,
  input  logic HRESET,
  input  logic raw_n,
  output logic level,
  output logic fall,
  output logic rise
);
  localparam int CW = cnt_w(N);

  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (raw_n != level) && (cnt == CW'(N - 1));
  assign fall = flip & ~raw_n;
  assign rise = flip &  raw_n;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (raw_n == level) begin
      cnt <= '0;
    end else if (flip) begin
      level <= raw_n;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Debounces mode/trip buttons and fork/crank reeds into registered 1-cycle strobes.
// Define INPUT_COMBO_EN to add the mode+trip ComboLong detector.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REED_CYCLES     = DEF_REED_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
)(
  input logic         HCLK,
  input logic         HRESET,
  input_cond_if.slave bus
);
  localparam int            LW       = cnt_w(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_END = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] ARM_END  = LW'(DEBOUNCE_CYCLES - 1);

  // index 0 = mode, 1 = trip; reeds 0 = fork, 1 = crank
  logic [1:0] btnRawN, btnFall, btnRise, unusedBtnLevel;
  logic [1:0] reedRawN, reedFall, reedRise, unusedReedLevel;

  assign btnRawN  = {bus.nTrip, bus.nMode};
  assign reedRawN = {bus.nCrank, bus.nFork};

  debounce_filter #(.N(DEBOUNCE_CYCLES)) uBtnFilt [1:0] (
    .HCLK(HCLK), .HRESET(HRESET), .raw_n(btnRawN),
    .level(unusedBtnLevel), .fall(btnFall), .rise(btnRise)
  );

  debounce_filter #(.N(REED_CYCLES)) uReedFilt [1:0] (
    .HCLK(HCLK), .HRESET(HRESET), .raw_n(reedRawN),
    .level(unusedReedLevel), .fall(reedFall), .rise(reedRise)
  );

  btn_state_t    state [2], stateNext [2];
  logic [LW-1:0] cnt [2], cntNext [2];
  logic [1:0]    pressed, holdLong, shortNext, longNext;
  logic [1:0]    shortQ, longQ, reedQ;

`ifdef INPUT_COMBO_EN
  logic comboLatch, latchNext, comboNext, comboQ;
`endif

  always_comb begin
    for (int b = 0; b < 2; b++) pressed[b] = (state[b] == HELD) || (state[b] == LONGHELD);
  end

  // With the combo enabled a single long press waits while the other button is down.
`ifdef INPUT_COMBO_EN
  assign holdLong = {comboLatch | pressed[0], comboLatch | pressed[1]};
`else
  assign holdLong = 2'b00;
`endif

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      stateNext[b] = state[b];
      cntNext[b]   = cnt[b];
      shortNext[b] = 1'b0;
      longNext[b]  = 1'b0;
      case (state[b])
        // ARM reuses the long counter as a consecutive-released-samples counter
        ARM: begin
          if (!btnRawN[b])              cntNext[b] = '0;
          else if (cnt[b] == ARM_END) begin
            stateNext[b] = IDLE;
            cntNext[b]   = '0;
          end else                      cntNext[b] = cnt[b] + LW'(1);
        end
        IDLE: begin
          if (btnFall[b]) begin
            stateNext[b] = HELD;
            cntNext[b]   = '0;
          end
        end
        HELD: begin
          if (btnRise[b]) begin
            stateNext[b] = IDLE;
            shortNext[b] = 1'b1;
          end else begin
            cntNext[b] = (cnt[b] == LONG_END) ? cnt[b] : cnt[b] + LW'(1);
            if (cnt[b] == LONG_END && !holdLong[b]) begin
              stateNext[b] = LONGHELD;
              longNext[b]  = 1'b1;
            end
          end
        end
        LONGHELD: begin
          if (btnRise[b]) stateNext[b] = IDLE;
          else            cntNext[b] = (cnt[b] == LONG_END) ? cnt[b] : cnt[b] + LW'(1);
        end
        default: stateNext[b] = ARM;
      endcase
    end

`ifdef INPUT_COMBO_EN
    comboNext = 1'b0;
    latchNext = comboLatch;
    // both counters saturate at LONG_END, so the later press sets the threshold
    if (!comboLatch && (&pressed) && !(|btnRise) &&
        cnt[0] == LONG_END && cnt[1] == LONG_END) begin
      comboNext    = 1'b1;
      latchNext    = 1'b1;
      stateNext[0] = LONGHELD;
      stateNext[1] = LONGHELD;
      longNext     = 2'b00;
    end else if (comboLatch && !(|pressed)) begin
      latchNext = 1'b0;
    end
`endif
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int b = 0; b < 2; b++) begin
        state[b] <= ARM;
        cnt[b]   <= '0;
      end
      shortQ <= '0;
      longQ  <= '0;
      reedQ  <= '0;
`ifdef INPUT_COMBO_EN
      comboLatch <= 1'b0;
      comboQ     <= 1'b0;
`endif
    end else begin
      for (int b = 0; b < 2; b++) begin
        state[b] <= stateNext[b];
        cnt[b]   <= cntNext[b];
      end
      shortQ <= shortNext;
      longQ  <= longNext;
      reedQ  <= reedFall;
`ifdef INPUT_COMBO_EN
      comboLatch <= latchNext;
      comboQ     <= comboNext;
`endif
    end
  end

  assign bus.ModeShort  = shortQ[0];
  assign bus.TripShort  = shortQ[1];
  assign bus.ModeLong   = longQ[0];
  assign bus.TripLong   = longQ[1];
  assign bus.ForkPulse  = reedQ[0];
  assign bus.CrankPulse = reedQ[1];
`ifdef INPUT_COMBO_EN
  assign bus.ComboLong  = comboQ;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE=4, REED=2, LONG=20.
module tb_input_conditioner;
  logic HCLK = 1'b0;
  logic HRESET;
  int   checks = 0;
  int   errors = 0;
  int   nModeShort = 0, nModeLong = 0, nTripShort = 0, nTripLong = 0;
  int   nFork = 0, nCrank = 0, nCombo = 0;
  logic [6:0] outs;

  input_cond_if bus();

  input_conditioner #(.DEBOUNCE_CYCLES(4), .REED_CYCLES(2), .LONG_CYCLES(20)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
  );

  always #5 HCLK = ~HCLK;

`ifdef INPUT_COMBO_EN
  assign outs = {bus.ComboLong, bus.ModeShort, bus.ModeLong, bus.TripShort,
                 bus.TripLong, bus.ForkPulse, bus.CrankPulse};
`else
  assign outs = {1'b0, bus.ModeShort, bus.ModeLong, bus.TripShort,
                 bus.TripLong, bus.ForkPulse, bus.CrankPulse};
`endif

  always @(negedge HCLK) begin
    if (bus.ModeShort)  nModeShort++;
    if (bus.ModeLong)   nModeLong++;
    if (bus.TripShort)  nTripShort++;
    if (bus.TripLong)   nTripLong++;
    if (bus.ForkPulse)  nFork++;
    if (bus.CrankPulse) nCrank++;
    if (outs[6])        nCombo++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    HRESET = 1'b1;
    bus.nMode = 1'b1; bus.nTrip = 1'b1; bus.nFork = 1'b1; bus.nCrank = 1'b1;
    tick(3);
    chk("reset_outs", 32'(outs), 0);
    HRESET = 1'b0;
    tick(10);

    // 1: fork latency, glitches, 100 clean events
    bus.nFork = 1'b0;
    tick(1); chk("fork_early", 32'(bus.ForkPulse), 0);
    tick(1); chk("fork_pulse", 32'(bus.ForkPulse), 1);
    tick(1); chk("fork_after", 32'(bus.ForkPulse), 0);
    tick(3); bus.nFork = 1'b1;
    tick(4);
    repeat (3) begin
      bus.nFork = 1'b0; tick(1);
      bus.nFork = 1'b1; tick(4);
    end
    chk("fork_glitch", 32'(nFork), 1);
    repeat (100) begin
      bus.nFork = 1'b0; tick(3);
      bus.nFork = 1'b1; tick(3);
    end
    chk("fork_100", 32'(nFork), 101);

    // 2: mode short press, released after 10 cycles low
    bus.nMode = 1'b0; tick(10);
    bus.nMode = 1'b1;
    tick(3); chk("mode_short_early", 32'(bus.ModeShort), 0);
    tick(1); chk("mode_short", 32'(bus.ModeShort), 1);
    tick(1); chk("mode_short_after", 32'(bus.ModeShort), 0);
    bus.nMode = 1'b0; tick(3);
    bus.nMode = 1'b1; tick(6);
    chk("mode_blip", 32'(nModeShort), 1);
    chk("mode_nolong", 32'(nModeLong), 0);

    // 3: trip long press, filtered press at +4, long at +24
    bus.nTrip = 1'b0;
    tick(23); chk("trip_long_early", 32'(bus.TripLong), 0);
    tick(1);  chk("trip_long", 32'(bus.TripLong), 1);
    tick(1);  chk("trip_long_after", 32'(bus.TripLong), 0);
    tick(15); bus.nTrip = 1'b1;
    tick(8);
    chk("trip_long_cnt", 32'(nTripLong), 1);
    chk("trip_noshort", 32'(nTripShort), 0);

    // 4: mode held through reset never registers
    HRESET = 1'b1; bus.nMode = 1'b0;
    tick(3);
    HRESET = 1'b0;
    tick(30); bus.nMode = 1'b1;
    tick(10);
    chk("arm_noshort", 32'(nModeShort), 1);
    chk("arm_nolong", 32'(nModeLong), 0);
    bus.nMode = 1'b0; tick(8);
    bus.nMode = 1'b1;
    tick(3); chk("arm_then_early", 32'(bus.ModeShort), 0);
    tick(1); chk("arm_then_short", 32'(bus.ModeShort), 1);
    tick(4);

    // 5: reset mid long count, then simultaneous reeds
    bus.nMode = 1'b0; tick(4 + 15);
    HRESET = 1'b1;
    tick(1); chk("midreset_outs", 32'(outs), 0);
    bus.nMode = 1'b1; tick(2);
    HRESET = 1'b0; tick(25);
    chk("midreset_nolong", 32'(nModeLong), 0);
    chk("midreset_noshort", 32'(nModeShort), 2);
    bus.nFork = 1'b0; bus.nCrank = 1'b0;
    tick(2); chk("reed_same_cycle", 32'({bus.ForkPulse, bus.CrankPulse}), 3);
    tick(1); bus.nFork = 1'b1; bus.nCrank = 1'b1;
    tick(4);
    chk("fork_total", 32'(nFork), 102);
    chk("crank_total", 32'(nCrank), 1);

`ifdef INPUT_COMBO_EN
    // 6: mode at t0, trip at t0+5, combo at trip press + 4 + 20
    bus.nMode = 1'b0; tick(5);
    bus.nTrip = 1'b0;
    tick(23); chk("combo_early", 32'(outs[6]), 0);
    tick(1);  chk("combo_pulse", 32'(outs[6]), 1);
    tick(17); bus.nMode = 1'b1; bus.nTrip = 1'b1;
    tick(10);
    chk("combo_cnt", 32'(nCombo), 1);
    chk("combo_nolong", 32'(nModeLong + nTripLong), 1);
    chk("combo_noshort", 32'(nModeShort + nTripShort), 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
